// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited request issue, in-order response pairing
// with a PC queue, a fetch buffer toward decode, and redirect-driven response discard.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_C = 16'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] cnt_q, cnt_d, out_q, out_d, disc_q, disc_d;
    logic [PW-1:0] brd_q, brd_d, bwr_q, bwr_d, qrd_q, qrd_d, qwr_q, qwr_d;

    logic [31:0] buf_instr_q [DEPTH];
    logic [31:0] buf_pc_q    [DEPTH];
    logic [31:0] pcq_q       [DEPTH];

    logic req, grant, rv_any, rv_drop, rv_keep, vld, pop;
    logic unused_pc_lsb;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        req     = !rst && !redirect_i && ((cnt_q + out_q) < DEPTH_C);
        grant   = req && imem_gnt_i;
        // Responses with nothing in flight (e.g. left over from before reset) are ignored.
        rv_any  = imem_rvalid_i && ((out_q != '0) || (disc_q != '0));
        rv_drop = rv_any && (redirect_i || (disc_q != '0));
        rv_keep = rv_any && !rv_drop;
        vld     = (cnt_q != '0) && !redirect_i;
        pop     = vld && ready_i;

        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        disc_d     = disc_q;
        brd_d      = brd_q;
        bwr_d      = bwr_q;
        qrd_d      = qrd_q;
        qwr_d      = qwr_q;

        if (redirect_i) begin
            // Everything still in flight after this cycle becomes discard-only; new
            // requests then start from zero outstanding and earn credits normally.
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            disc_d     = disc_q + out_q + {15'd0, grant} - {15'd0, rv_any};
            out_d      = '0;
            cnt_d      = '0;
            brd_d      = '0;
            bwr_d      = '0;
            qrd_d      = '0;
            qwr_d      = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                qwr_d      = ptr_inc(qwr_q);
            end
            if (rv_drop) begin
                disc_d = disc_q - 16'd1;
            end
            if (rv_keep) begin
                qrd_d = ptr_inc(qrd_q);
                bwr_d = ptr_inc(bwr_q);
            end
            if (pop) begin
                brd_d = ptr_inc(brd_q);
            end
            out_d = out_q + {15'd0, grant} - {15'd0, rv_keep};
            cnt_d = cnt_q + {15'd0, rv_keep} - {15'd0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            brd_q      <= '0;
            bwr_q      <= '0;
            qrd_q      <= '0;
            qwr_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            brd_q      <= brd_d;
            bwr_q      <= bwr_d;
            qrd_q      <= qrd_d;
            qwr_q      <= qwr_d;
        end
    end

    // Storage arrays are qualified by the counters, so they carry no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            pcq_q[qwr_q] <= fetch_pc_q;
        end
        if (rv_keep) begin
            buf_instr_q[bwr_q] <= imem_rdata_i;
            buf_pc_q[bwr_q]    <= pcq_q[qrd_q];
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign valid_o       = vld;
    assign instr_o       = (cnt_q != '0) ? buf_instr_q[brd_q] : 32'd0;
    assign pc_o          = (cnt_q != '0) ? buf_pc_q[brd_q]    : 32'd0;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];

endmodule
